// File: rtl/div_shift_sub_pkg.sv
// Shared definitions for the shift-subtract divider.
//   div_state_t : controller states (IDLE, RUN, DONE)
//   DIV_W       : default operand width
//   DIV_ZERO_Q  : quotient returned on divide-by-zero and on the error path
package div_pkg;

  localparam int DIV_W = 32;

  localparam logic [DIV_W-1:0] DIV_ZERO_Q = '1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } div_state_t;

endpackage : div_pkg

// File: rtl/div_shift_sub_step.sv
// One restoring-division step: compare the partial remainder against the
// current divisor and subtract when it fits, shifting the new quotient bit
// into the accumulator.
// Ports:
//   i_rem    : partial remainder
//   i_d      : current (shifted) divisor
//   i_qacc   : quotient accumulator
//   o_rem_n  : remainder after the step
//   o_qacc_n : quotient accumulator after the step
module div_step #(
  parameter int W = 32
) (
  input  logic [W-1:0] i_rem,
  input  logic [W-1:0] i_d,
  input  logic [W-1:0] i_qacc,
  output logic [W-1:0] o_rem_n,
  output logic [W-1:0] o_qacc_n
);

  logic w_ge;

  // The subtract only happens when it fits, so it never borrows.
  always_comb begin
    w_ge     = (i_rem >= i_d);
    o_rem_n  = w_ge ? (i_rem - i_d) : i_rem;
    o_qacc_n = {i_qacc[W-2:0], w_ge};
  end

endmodule : div_step

// File: rtl/div_shift_sub.sv
// Iterative unsigned shift-subtract divider (MIPS DIVU) that takes the
// divisor b together with its pre-aligned copy shiftb = b << k and walks the
// divisor back down one bit per cycle, one quotient bit per cycle.
//
// state | meaning
// ------+---------------------------------------------------------
// IDLE  | o_in_ready=1, waiting for operands
// RUN   | one compare/subtract step per cycle
// DONE  | o_out_valid=1, q/r/err held until the consumer takes them
//
// Ports:
//   i_clk, i_rst          : clock, asynchronous active-high reset
//   i_in_valid/o_in_ready : operand handshake
//   i_a, i_b, i_shiftb    : dividend, divisor, aligned divisor
//   o_out_valid/i_out_ready : result handshake
//   o_q, o_r              : quotient (LO), remainder (HI)
//   o_err                 : shiftb was not a lossless left shift of b
module div_shift_sub
  import div_pkg::*;
#(
  parameter int W = DIV_W
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_in_valid,
  output logic         o_in_ready,
  input  logic [W-1:0] i_a,
  input  logic [W-1:0] i_b,
  input  logic [W-1:0] i_shiftb,
  output logic         o_out_valid,
  input  logic         i_out_ready,
  output logic [W-1:0] o_q,
  output logic [W-1:0] o_r,
  output logic         o_err
);

  localparam int CNT_W = $clog2(W) + 1;
  localparam logic [W-1:0]     L_ALL_ONES = '1;
  localparam logic [CNT_W-1:0] L_LAST_STEP = CNT_W'(W - 1);

  div_state_t       r_state;
  logic             r_in_ready;
  logic             r_out_valid;
  logic [W-1:0]     r_a;
  logic [W-1:0]     r_b;
  logic [W-1:0]     r_rem;
  logic [W-1:0]     r_d;
  logic [W-1:0]     r_qacc;
  logic [CNT_W-1:0] r_cnt;
  logic [W-1:0]     r_q;
  logic [W-1:0]     r_r;
  logic             r_err;

  logic [W-1:0]     w_rem_n;
  logic [W-1:0]     w_qacc_n;

  div_step #(.W(W)) u_step (
    .i_rem    (r_rem),
    .i_d      (r_d),
    .i_qacc   (r_qacc),
    .o_rem_n  (w_rem_n),
    .o_qacc_n (w_qacc_n)
  );

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state     <= IDLE;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_a         <= '0;
      r_b         <= '0;
      r_rem       <= '0;
      r_d         <= '0;
      r_qacc      <= '0;
      r_cnt       <= '0;
      r_q         <= '0;
      r_r         <= '0;
      r_err       <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (i_in_valid) begin
            r_a <= i_a;
            r_b <= i_b;
            if (i_b == '0) begin
              r_q         <= L_ALL_ONES;
              r_r         <= i_a;
              r_err       <= 1'b0;
              r_state     <= DONE;
              r_in_ready  <= 1'b0;
              r_out_valid <= 1'b1;
            end else if (i_a < i_b) begin
              r_q         <= '0;
              r_r         <= i_a;
              r_err       <= 1'b0;
              r_state     <= DONE;
              r_in_ready  <= 1'b0;
              r_out_valid <= 1'b1;
            end else begin
              r_rem      <= i_a;
              r_d        <= i_shiftb;
              r_qacc     <= '0;
              r_cnt      <= '0;
              r_state    <= RUN;
              r_in_ready <= 1'b0;
            end
          end
        end

        RUN: begin
          r_rem  <= w_rem_n;
          r_qacc <= w_qacc_n;
          r_cnt  <= r_cnt + CNT_W'(1);
          // Reaching the unshifted divisor means this was the last quotient bit.
          if (r_d == r_b) begin
            r_q         <= w_qacc_n;
            r_r         <= w_rem_n;
            r_err       <= 1'b0;
            r_state     <= DONE;
            r_out_valid <= 1'b1;
          end else if (r_cnt == L_LAST_STEP) begin
            // W steps without meeting b: the alignment input was inconsistent.
            r_q         <= L_ALL_ONES;
            r_r         <= r_a;
            r_err       <= 1'b1;
            r_state     <= DONE;
            r_out_valid <= 1'b1;
          end else begin
            r_d <= r_d >> 1;
          end
        end

        DONE: begin
          if (i_out_ready) begin
            r_state     <= IDLE;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
          end
        end

        default: begin
          r_state     <= IDLE;
          r_in_ready  <= 1'b1;
          r_out_valid <= 1'b0;
        end
      endcase
    end
  end

  assign o_in_ready  = r_in_ready;
  assign o_out_valid = r_out_valid;
  assign o_q         = r_q;
  assign o_r         = r_r;
  assign o_err       = r_err;

endmodule : div_shift_sub

// File: tb/tb_div_shift_sub.sv
module tb_div_shift_sub;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] a;
  logic [31:0] b;
  logic [31:0] shiftb;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] q;
  logic [31:0] r;
  logic        err;

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  div_shift_sub #(.W(32)) dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_in_valid  (in_valid),
    .o_in_ready  (in_ready),
    .i_a         (a),
    .i_b         (b),
    .i_shiftb    (shiftb),
    .o_out_valid (out_valid),
    .i_out_ready (out_ready),
    .o_q         (q),
    .o_r         (r),
    .o_err       (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_in_ready"},  32'(in_ready),  32'd1);
    chk({tag, "_out_valid"}, 32'(out_valid), 32'd0);
    chk({tag, "_q"},         q,              32'd0);
    chk({tag, "_r"},         r,              32'd0);
    chk({tag, "_err"},       32'(err),       32'd0);
  endtask

  // Present one operand set, count edges after the accept edge until
  // out_valid, then check latency and results. Inputs are scrambled right
  // after the accept to confirm the block works from latched copies.
  task automatic run_div(input string tag, input logic [31:0] ta, input logic [31:0] tb,
                         input logic [31:0] tsb, input int exp_lat,
                         input logic [31:0] exp_q, input logic [31:0] exp_r,
                         input logic exp_err, input logic release_out);
    int lat;
    a = ta; b = tb; shiftb = tsb; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    a = 32'hDEAD_BEEF; b = 32'h0000_0003; shiftb = 32'h0000_0C00;
    if (exp_lat > 0) chk({tag, "_busy"}, 32'(in_ready), 32'd0);
    lat = 0;
    while (!out_valid && lat < 100) begin
      tick();
      lat++;
    end
    chk({tag, "_lat"}, 32'(lat), 32'(exp_lat));
    chk({tag, "_q"},   q,        exp_q);
    chk({tag, "_r"},   r,        exp_r);
    chk({tag, "_err"}, 32'(err), 32'(exp_err));
    if (release_out) begin
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      chk({tag, "_idle"},   32'(in_ready),  32'd1);
      chk({tag, "_noval"},  32'(out_valid), 32'd0);
    end
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    a = '0; b = '0; shiftb = '0;
    #1;
    chk_reset_outputs("rst0");
    tick();
    tick();
    rst = 1'b0;
    chk_reset_outputs("rst1");

    // 100/7, k=3: four steps
    run_div("d100_7", 32'd100, 32'd7, 32'd56, 4, 32'd14, 32'd2, 1'b0, 1'b1);
    // full-width: k=31
    run_div("dmax_1", 32'hFFFF_FFFF, 32'd1, 32'h8000_0000, 32,
            32'hFFFF_FFFF, 32'd0, 1'b0, 1'b1);
    // divide by zero
    run_div("dzero", 32'h0000_1234, 32'd0, 32'd0, 0,
            32'hFFFF_FFFF, 32'h0000_1234, 1'b0, 1'b1);
    // dividend smaller than divisor
    run_div("d5_9", 32'd5, 32'd9, 32'd9, 0, 32'd0, 32'd5, 1'b0, 1'b1);
    // shiftb not a shift of b
    run_div("derr", 32'd50, 32'd6, 32'h38, 32,
            32'hFFFF_FFFF, 32'd50, 1'b1, 1'b1);
    // k=0, exact division: one step
    run_div("d42_42", 32'd42, 32'd42, 32'd42, 1, 32'd1, 32'd0, 1'b0, 1'b1);

    // Backpressure: hold out_ready low, offer new operands meanwhile
    run_div("bp", 32'd100, 32'd7, 32'd56, 4, 32'd14, 32'd2, 1'b0, 1'b0);
    a = 32'd9; b = 32'd3; shiftb = 32'd3; in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("bp_hold_q",     q,               32'd14);
      chk("bp_hold_r",     r,               32'd2);
      chk("bp_hold_valid", 32'(out_valid),  32'd1);
      chk("bp_hold_ready", 32'(in_ready),   32'd0);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("bp_release_idle",  32'(in_ready),  32'd1);
    chk("bp_release_noval", 32'(out_valid), 32'd0);
    tick();
    chk("bp_nothing_latched", 32'(out_valid), 32'd0);
    chk("bp_still_idle",      32'(in_ready),  32'd1);

    // Reset two cycles into a run
    a = 32'd100; b = 32'd7; shiftb = 32'd56; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    chk("mid_busy", 32'(in_ready), 32'd0);
    rst = 1'b1;
    #1;
    chk_reset_outputs("mid_rst");
    tick();
    rst = 1'b0;
    chk_reset_outputs("mid_rel");
    tick();
    chk("mid_no_pulse", 32'(out_valid), 32'd0);
    run_div("d20_3", 32'd20, 32'd3, 32'd12, 3, 32'd6, 32'd2, 1'b0, 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule : tb_div_shift_sub

// File: doc/div_shift_sub.md
# div_shift_sub

Iterative unsigned shift-subtract divider that consumes a pre-aligned divisor and produces quotient and remainder for MIPS DIVU. It sits after the divisor-alignment stage: it takes `b` and its left-aligned copy `shiftb = b << k`, then walks the divisor back down one bit per cycle, producing one quotient bit per cycle. The HI/LO writeback logic reads the results through a valid/ready handshake. Signed DIV is handled by a sign-fixup wrapper outside this block.

## Interface
- `W`, default 32: operand width.
- `clk`  in  1  clock; all flops on rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `in_valid`  in  1  operands valid.
- `in_ready`  out  1  block idle; can accept operands.
- `a`  in  W  dividend.
- `b`  in  W  divisor.
- `shiftb`  in  W  aligned divisor; must equal `b << k` for some k in 0..W-1 with no bits lost.
- `out_valid`  out  1  result valid.
- `out_ready`  in  1  consumer takes the result.
- `q`  out  W  quotient (to LO).
- `r`  out  W  remainder (to HI).
- `err`  out  1  `shiftb` inconsistent with `b`; `q`/`r` are defined fallback values.

## Operation
- States:
  - IDLE: `in_ready`=1.
  - RUN: iterating.
  - DONE: `out_valid`=1.
- Accept occurs on a rising edge with `in_valid & in_ready`.
  - The block latches `a`, `b`, and `shiftb`.
  - Later changes on the inputs are ignored until the next accept.
- Special cases at accept go directly to DONE:
  - `b==0`: `q`=all-ones, `r`=`a`, `err`=0.
  - `a<b` (and `b!=0`): `q`=0, `r`=`a`, `err`=0.
- Normal path at accept:
  - Load `rem=a`, `d=shiftb`, `qacc=0`, `cnt=0`; go to RUN.
- Each RUN cycle performs one step:
  - If `rem>=d`: `rem-=d`, `qacc=(qacc<<1)|1`.
  - Otherwise: `qacc=qacc<<1`.
  - Then `cnt+=1`.
  - If `d==b` (compared before shifting): go to DONE with `q=qacc`, `r=rem`.
  - Otherwise: `d>>=1`.
- `shiftb>a` is legal; the leading steps simply yield 0 quotient bits.
- Error path: if W steps complete without `d==b` (bits lost, `shiftb` not a shift of `b`, or `shiftb==0`):
  - Go to DONE with `err`=1, `q`=all-ones, `r`=`a`.
- DONE holds `q`, `r`, and `err` stable until `out_valid & out_ready`, then returns to IDLE.
- Arithmetic: `rem` and `d` are W bits. The subtract only happens when `rem>=d`, so there is no borrow. `cnt` is `$clog2(W)+1` bits.

## Timing
- Reset values: state=IDLE, `in_ready`=1, `out_valid`=0, `q`=0, `r`=0, `err`=0, all internal registers 0.
- `in_ready` and `out_valid` are decoded from registered state; no combinational path from `in_valid` or `out_ready`.
- Special-case latency: accept at edge 0; `out_valid` high after edge 0.
- Normal latency: accept at edge 0; steps on edges 1..k+1; `out_valid` high after edge k+1. Worst case (k=W-1) is W steps.
- Error latency: `out_valid` high after edge W.
- The edge where `out_valid & out_ready` returns to IDLE; the earliest next accept is the following edge (no same-cycle turnaround).
- `in_valid` while not IDLE is ignored and nothing is latched.
- `rst` asserted mid-RUN or in DONE aborts immediately to reset values. The result is discarded and no `out_valid` pulse is produced.

## Structure
- Shared package `div_pkg`:
  - `div_state_t` enum {IDLE, RUN, DONE}.
  - `DIV_W` = 32.
  - Constant `DIV_ZERO_Q` = all-ones.
- Optional sub-module `div_step`: combinational compare/subtract, with
  - inputs `rem`, `d`, `qacc`;
  - outputs `rem_n`, `qacc_n`.
- The FSM and registers stay in `div_shift_sub`.

## Test plan
- `a`=100, `b`=7, `shiftb`=56 (k=3) → 4 steps; `q`=14, `r`=2, `err`=0; `out_valid` after edge 4.
- `a`=0xFFFFFFFF, `b`=1, `shiftb`=0x80000000 → 32 steps; `q`=0xFFFFFFFF, `r`=0; `out_valid` after edge 32.
- `b`=0, `a`=0x1234 → `q`=0xFFFFFFFF, `r`=0x1234, `err`=0 after edge 0. Separately, `a`=5, `b`=9 → `q`=0, `r`=5 after edge 0.
- `a`=50, `b`=6, `shiftb`=0x38 (not a shift of 6) → `err`=1, `q`=0xFFFFFFFF, `r`=50 after edge 32.
- Backpressure: 100/7 case with `out_ready` low for 3 cycles after `out_valid` → `q`/`r` stable, `in_ready`=0, a new `in_valid` is ignored. Raise `out_ready` → IDLE on the next edge.
- Assert `rst` two cycles into the 100/7 run → all outputs at reset values immediately. After release, a fresh 20/3 (`shiftb`=12) gives `q`=6, `r`=2.
